// File: rtl/dcache_mshr.sv
// Non-blocking data-cache miss handler: NUM_MSHR miss entries, same-block merging, tag-matched fills.
// Optional `DCACHE_MSHR_STATS_EN adds saturating alloc/merge/reject counters.
module dcache_mshr #(
    parameter int NUM_MSHR = 4,
    parameter int NUM_TGT  = 2,
    parameter int NUM_REQ  = 2,
    parameter int ADDR_W   = 32,
    parameter int BLK_OFF  = 3,
    parameter int TAG_W    = 4,
    parameter int LQ_IDX_W = 3
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         squash,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
    input  logic [NUM_REQ*LQ_IDX_W-1:0]  req_lq_idx,
    output logic [NUM_REQ-1:0]           req_accept,
    output logic                         mem_cmd_load,
    output logic [ADDR_W-1:0]            mem_addr,
    input  logic [TAG_W-1:0]             mem_transaction_tag,
    input  logic [63:0]                  mem_data,
    input  logic [TAG_W-1:0]             mem_data_tag,
    output logic                         fill_valid,
    output logic [ADDR_W-1:0]            fill_addr,
    output logic [63:0]                  fill_data,
    output logic [NUM_TGT-1:0]           resp_valid,
    output logic [NUM_TGT*LQ_IDX_W-1:0]  resp_lq_idx,
    output logic [63:0]                  resp_data,
    output logic                         mshr_full
`ifdef DCACHE_MSHR_STATS_EN
    ,
    output logic [31:0]                  stat_alloc,
    output logic [31:0]                  stat_merge,
    output logic [31:0]                  stat_reject
`endif
);

    localparam int BLK_W = ADDR_W - BLK_OFF;
    localparam int CNT_W = $clog2(NUM_TGT + 1);
    localparam int IDX_W = (NUM_MSHR > 1) ? $clog2(NUM_MSHR) : 1;
    localparam int REQ_W = $clog2(NUM_REQ + 1);

    typedef enum logic [1:0] {ST_INVALID = 2'd0, ST_PENDING = 2'd1, ST_WAIT = 2'd2} state_e;

    typedef struct packed {
        state_e                             state;
        logic [BLK_W-1:0]                   blk;
        logic [TAG_W-1:0]                   tag;
        logic [CNT_W-1:0]                   cnt;
        logic [NUM_TGT-1:0][LQ_IDX_W-1:0]   tgt;
        logic                               squashed;
    } entry_t;

    entry_t ent_q [NUM_MSHR];
    entry_t ent_d [NUM_MSHR];

    logic               fill_hit;
    logic [IDX_W-1:0]   fill_idx;
    logic               iss_hit;
    logic [IDX_W-1:0]   iss_idx;
    logic [NUM_TGT-1:0] resp_valid_d;

    logic [BLK_W-1:0]    rblk;
    logic [LQ_IDX_W-1:0] rlq;
    logic                match_f, free_f;
    logic [IDX_W-1:0]    match_i, free_i;
    logic [REQ_W-1:0]    n_alloc, n_merge, n_reject;

    // Fill and issue both pick the lowest-index qualifying entry.
    always_comb begin
        fill_hit = 1'b0;
        fill_idx = '0;
        iss_hit  = 1'b0;
        iss_idx  = '0;
        for (int i = NUM_MSHR - 1; i >= 0; i--) begin
            if (mem_data_tag != '0 && ent_q[i].state == ST_WAIT && ent_q[i].tag == mem_data_tag) begin
                fill_hit = 1'b1;
                fill_idx = IDX_W'(i);
            end
            if (ent_q[i].state == ST_PENDING) begin
                iss_hit = 1'b1;
                iss_idx = IDX_W'(i);
            end
        end
    end

    assign mem_cmd_load = iss_hit && !squash;
    assign mem_addr     = {ent_q[iss_idx].blk, {BLK_OFF{1'b0}}};

    always_comb begin
        mshr_full = 1'b1;
        for (int i = 0; i < NUM_MSHR; i++) begin
            if (ent_q[i].state == ST_INVALID) mshr_full = 1'b0;
        end
    end

    // NOTE: every variable gets a default at the top of the block so no path leaves a
    // latch behind; blocking '=' here lets later ports see earlier ports' allocations.
    always_comb begin
        for (int i = 0; i < NUM_MSHR; i++) ent_d[i] = ent_q[i];
        req_accept = '0;
        n_alloc    = '0;
        n_merge    = '0;
        n_reject   = '0;
        rblk       = '0;
        rlq        = '0;
        match_f    = 1'b0;
        match_i    = '0;
        free_f     = 1'b0;
        free_i     = '0;

        for (int p = 0; p < NUM_REQ; p++) begin
            if (req_valid[p]) begin
                rblk    = req_addr[p*ADDR_W+BLK_OFF +: BLK_W];
                rlq     = req_lq_idx[p*LQ_IDX_W +: LQ_IDX_W];
                match_f = 1'b0;
                match_i = '0;
                free_f  = 1'b0;
                free_i  = '0;
                for (int i = NUM_MSHR - 1; i >= 0; i--) begin
                    if (ent_d[i].state != ST_INVALID && !ent_d[i].squashed && ent_d[i].blk == rblk) begin
                        match_f = 1'b1;
                        match_i = IDX_W'(i);
                    end
                    if (ent_d[i].state == ST_INVALID) begin
                        free_f = 1'b1;
                        free_i = IDX_W'(i);
                    end
                end
                // A block being filled this cycle is rejected: the retry will hit the cache.
                if (squash || (fill_hit && ent_q[fill_idx].blk == rblk)) begin
                    n_reject = n_reject + REQ_W'(1);
                end else if (match_f) begin
                    if (ent_d[match_i].cnt < CNT_W'(NUM_TGT)) begin
                        for (int k = 0; k < NUM_TGT; k++) begin
                            if (CNT_W'(k) == ent_d[match_i].cnt) ent_d[match_i].tgt[k] = rlq;
                        end
                        ent_d[match_i].cnt = ent_d[match_i].cnt + CNT_W'(1);
                        req_accept[p] = 1'b1;
                        n_merge = n_merge + REQ_W'(1);
                    end else begin
                        n_reject = n_reject + REQ_W'(1);
                    end
                end else if (free_f) begin
                    ent_d[free_i].state    = ST_PENDING;
                    ent_d[free_i].blk      = rblk;
                    ent_d[free_i].tag      = '0;
                    ent_d[free_i].cnt      = CNT_W'(1);
                    ent_d[free_i].tgt      = '0;
                    ent_d[free_i].tgt[0]   = rlq;
                    ent_d[free_i].squashed = 1'b0;
                    req_accept[p] = 1'b1;
                    n_alloc = n_alloc + REQ_W'(1);
                end else begin
                    n_reject = n_reject + REQ_W'(1);
                end
            end
        end

        if (mem_cmd_load && mem_transaction_tag != '0) begin
            ent_d[iss_idx].state = ST_WAIT;
            ent_d[iss_idx].tag   = mem_transaction_tag;
        end
        if (fill_hit) ent_d[fill_idx].state = ST_INVALID;
        if (squash) begin
            for (int i = 0; i < NUM_MSHR; i++) begin
                if (ent_d[i].state == ST_PENDING) ent_d[i].state = ST_INVALID;
                else if (ent_d[i].state == ST_WAIT) ent_d[i].squashed = 1'b1;
            end
        end
    end

    // A fill that lands in the squash cycle still writes the cache but wakes no loads.
    always_comb begin
        resp_valid_d = '0;
        for (int k = 0; k < NUM_TGT; k++) begin
            resp_valid_d[k] = fill_hit && !ent_q[fill_idx].squashed && !squash &&
                              (CNT_W'(k) < ent_q[fill_idx].cnt);
        end
    end

    // NOTE: the entry array is reset in full; it is small, and a clean payload keeps
    // the fill/response outputs deterministic after reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_MSHR; i++) ent_q[i] <= '0;
            fill_valid  <= 1'b0;
            fill_addr   <= '0;
            fill_data   <= '0;
            resp_valid  <= '0;
            resp_lq_idx <= '0;
            resp_data   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking '<=' so all flops update together.
            for (int i = 0; i < NUM_MSHR; i++) ent_q[i] <= ent_d[i];
            fill_valid <= fill_hit;
            resp_valid <= resp_valid_d;
            if (fill_hit) begin
                fill_addr   <= {ent_q[fill_idx].blk, {BLK_OFF{1'b0}}};
                fill_data   <= mem_data;
                resp_lq_idx <= ent_q[fill_idx].tgt;
                resp_data   <= mem_data;
            end
        end
    end

    logic unused_addr_bits;
    always_comb begin
        unused_addr_bits = 1'b0;
        for (int p = 0; p < NUM_REQ; p++) begin
            unused_addr_bits = unused_addr_bits ^ (^req_addr[p*ADDR_W +: BLK_OFF]);
        end
    end

`ifdef DCACHE_MSHR_STATS_EN
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [REQ_W-1:0] b);
        logic [32:0] s;
        s = {1'b0, a} + 33'(b);
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stat_alloc  <= '0;
            stat_merge  <= '0;
            stat_reject <= '0;
        end else begin
            stat_alloc  <= sat_add(stat_alloc, n_alloc);
            stat_merge  <= sat_add(stat_merge, n_merge);
            stat_reject <= sat_add(stat_reject, n_reject);
        end
    end
`else
    logic unused_stats;
    assign unused_stats = ^{n_alloc, n_merge, n_reject};
`endif

endmodule

// File: doc/dcache_mshr.md
Name: dcache_mshr

Overview:
- Non-blocking miss handler for the data cache; replaces the single outstanding-miss path with NUM_MSHR parallel miss entries.
- Accepts up to NUM_REQ load misses per cycle from the dcache lookup stage.
- Merges misses to the same block and issues one MEM_LOAD per block.
- Matches returning data by memory tag; emits a cache fill plus per-target responses to the load queue.

Parameters:
NUM_MSHR, 4, number of miss entries
NUM_TGT, 2, load targets mergeable per entry
NUM_REQ, 2, miss request ports per cycle
ADDR_W, 32, address width
BLK_OFF, 3, block offset bits (8-byte MEM_BLOCK)
TAG_W, 4, memory tag width; tag 0 means "no transaction"
LQ_IDX_W, 3, load-queue index width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
squash  in  1  pipeline flush
req_valid  in  NUM_REQ  miss request valid
req_addr  in  NUM_REQ*ADDR_W  miss byte address
req_lq_idx  in  NUM_REQ*LQ_IDX_W  requesting LQ entry
req_accept  out  NUM_REQ  request captured this cycle (combinational)
mem_cmd_load  out  1  issue MEM_LOAD (combinational)
mem_addr  out  ADDR_W  block-aligned address, low BLK_OFF bits zero
mem_transaction_tag  in  TAG_W  nonzero = load accepted by memory this cycle
mem_data  in  64  returned block
mem_data_tag  in  TAG_W  nonzero = mem_data valid for that tag
fill_valid  out  1  write block into cache array (registered)
fill_addr  out  ADDR_W  block address of fill
fill_data  out  64  fill block
resp_valid  out  NUM_TGT  per-target LQ wakeup (registered)
resp_lq_idx  out  NUM_TGT*LQ_IDX_W  LQ index per target
resp_data  out  64  block data shared by all targets
mshr_full  out  1  no INVALID entry (registered state)

Behaviour:
- Entry fields: state, block address, tag, target count, target LQ indices, squashed bit.
- Entry states: INVALID, PENDING (needs issue), WAIT (issued, tag held).
- Reset (asserted low, async): all entries INVALID; all registered outputs 0; mshr_full = 0.
- Request ports are processed in order 0..NUM_REQ-1 within a cycle.
  - Request block matches a non-squashed PENDING/WAIT entry, or an entry allocated by a lower port this cycle, and target count < NUM_TGT: merge, accept.
  - Matching entry already has NUM_TGT targets: reject.
  - No match and an INVALID entry is free: allocate lowest-index free entry as PENDING with 1 target, accept.
  - No match and no free entry: reject.
  - Rejected requests are retried by the LSQ; the MSHR holds no state for them.
- Issue: lowest-index PENDING entry drives mem_cmd_load = 1 and mem_addr.
  - mem_transaction_tag != 0 same cycle: entry -> WAIT, tag latched.
  - mem_transaction_tag == 0: entry stays PENDING and retries next cycle.
  - At most one issue per cycle.
- Fill: mem_data_tag != 0 matching a WAIT entry's tag.
  - Next cycle: fill_valid = 1, fill_addr, fill_data = mem_data.
  - Next cycle, if entry not squashed: resp_valid[k] = 1 for k < target count, with resp_lq_idx and resp_data.
  - Entry -> INVALID at that same edge.
  - Tag matching no WAIT entry is ignored.
- Same-cycle fill and request to that block: request rejected; retry hits the filled cache.
- Same-cycle fill free and request allocate: freed entry is not reusable until the next cycle.
- Squash:
  - All PENDING entries -> INVALID.
  - WAIT entries set squashed; their fill is still written to the cache, with no resp_valid.
  - Requests in the squash cycle get req_accept = 0.
  - Issue is suppressed that cycle.
- Squashed entries never accept merges; a new miss to the same block allocates a separate entry.

Optional Feature:
DCACHE_MSHR_STATS_EN
- Defined: adds outputs stat_alloc, stat_merge, stat_reject, each 32 bits, saturating at all-ones, cleared by reset.
  - stat_alloc increments by the number of allocations per cycle.
  - stat_merge increments by the number of merges per cycle.
  - stat_reject increments by the number of rejects per cycle.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Single miss: req0 addr 0x8, lq 4 -> accept; mem_cmd_load = 1, mem_addr = 0x8. Tag 1 accepted. mem_data_tag = 1, data 0x12345678 -> next cycle fill_valid, resp_valid[0], lq 4, resp_data 0x12345678.
- Merge: port0 0x40 lq 1 and port1 0x44 lq 2 same cycle -> both accepted, one MEM_LOAD to 0x40. Fill -> resp_valid = 2'b11 with lq 1, 2. A third request to 0x40 before fill -> rejected.
- Full: 4 misses to 0x0/0x8/0x10/0x18 -> mshr_full = 1. Fifth miss 0x20 -> rejected. Fill one entry -> 0x20 accepted the cycle after.
- Issue retry: mem_transaction_tag = 0 for 3 cycles -> mem_cmd_load held with the same mem_addr. Tag 2 -> entry WAIT; next PENDING entry then issued.
- Squash: one PENDING and one WAIT (tag 3) entry; assert squash -> PENDING freed. Tag 3 data returns -> fill_valid = 1, resp_valid = 0.
- Reset mid-operation: reset asserted low while an entry is WAIT -> all outputs 0 immediately, mshr_full = 0. Later tag match -> no fill.
